// File: rtl/lupa_spi_cfg_slave_pkg.sv
// Shared constants and types for the LUPA300 configuration link receiver:
// register map, power-on defaults, frame geometry and frame FSM states.
package lupa_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 12;
  localparam int CNT_W      = 5;
  localparam int CNT_SAT    = 17;

  localparam logic [ADDR_W-1:0] ADDR_SEQUENCER  = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_START_Y    = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_START_X    = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_NB_X       = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_MODE       = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_RESERVED5  = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_RESERVED6  = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_NB_Y       = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_PGA_GAIN   = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_ADC_RANGE  = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_DAC_VREF   = 4'hA;
  localparam logic [ADDR_W-1:0] ADDR_OFFSET     = 4'hB;
  localparam logic [ADDR_W-1:0] ADDR_BIAS1      = 4'hC;
  localparam logic [ADDR_W-1:0] ADDR_BIAS2      = 4'hD;
  localparam logic [ADDR_W-1:0] ADDR_CALIB_ADC1 = 4'hE;
  localparam logic [ADDR_W-1:0] ADDR_CALIB_ADC2 = 4'hF;

  // Packed so that REG_DEFAULTS[addr] indexes naturally; listed from 0xF down to 0x0.
  localparam logic [15:0][DATA_W-1:0] REG_DEFAULTS = {
    12'h0DB, 12'h6DB, 12'hADF, 12'hFB0,
    12'h0F0, 12'h055, 12'h06B, 12'h04A,
    12'h1E1, 12'h000, 12'h000, 12'h002,
    12'h0A0, 12'h000, 12'h000, 12'h029
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL,
    ST_OVER
  } frame_state_t;

endpackage

// File: rtl/lupa_spi_cfg_slave_if.sv
// The three-wire LUPA300 configuration link as seen between master and sensor.
interface lupa_spi_cfg_slave_if;

  logic spi_clk;
  logic spi_en;
  logic spi_dat;

  modport master (output spi_clk, output spi_en, output spi_dat);
  modport slave  (input spi_clk, input spi_en, input spi_dat);

endinterface

// File: rtl/lupa_spi_cfg_slave_sync_edge.sv
// Brings one asynchronous link wire into the block clock domain and flags
// its rising edges using one extra flop behind the synchroniser.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              last;

  // Synchroniser chain followed by the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      last  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      last  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = chain[STAGES-1] & ~last;

endmodule

// File: rtl/lupa_spi_cfg_slave.sv
// Sensor-side receiver of the LUPA300 configuration link: oversamples the
// link, shifts in 16-bit address/data frames and commits them into a
// 16 x 12-bit register bank when the enable strobe rises.
module lupa_spi_cfg_slave
  import lupa_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock_80,
  input  logic                reset_n,
  lupa_spi_cfg_slave_if.slave link,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [10:0]         seq_reg,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                frame_err,
  output logic [7:0]          frame_count
);

  logic rise_clk, rise_en, en_sync, dat_sync;
  logic clk_level_unused, en_rise_pad_unused, dat_rise_unused;
  logic clk_accept;

  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      cnt;
  frame_state_t          state, state_next;
  logic                  do_commit, do_err;
  logic [DATA_W-1:0]     bank [16];

  sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(clock_80), .rst_n(reset_n), .async_in(link.spi_clk),
    .sync_out(clk_level_unused), .rise(rise_clk)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_en_sync (
    .clk(clock_80), .rst_n(reset_n), .async_in(link.spi_en),
    .sync_out(en_sync), .rise(rise_en)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
    .clk(clock_80), .rst_n(reset_n), .async_in(link.spi_dat),
    .sync_out(dat_sync), .rise(dat_rise_unused)
  );

  assign en_rise_pad_unused = 1'b0;

  // Link clock edges only count while the commit strobe is low, which also
  // drops a clock edge coinciding with the strobe's rising edge.
  assign clk_accept = rise_clk & ~en_sync;

  // Shift register and saturating bit counter; every commit attempt clears both.
  always_ff @(posedge clock_80 or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (rise_en) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clk_accept) begin
      sr <= {sr[FRAME_BITS-2:0], dat_sync};
      if (cnt != CNT_W'(CNT_SAT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clock_80 or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame progress: only a frame of exactly 16 accepted bits sits in FULL.
  always_comb begin
    state_next = state;
    if (rise_en) begin
      state_next = ST_IDLE;
    end else if (clk_accept) begin
      case (state)
        ST_IDLE:  state_next = ST_SHIFT;
        ST_SHIFT: if (cnt == CNT_W'(FRAME_BITS - 1)) state_next = ST_FULL;
        ST_FULL:  state_next = ST_OVER;
        default:  state_next = state;
      endcase
    end
  end

  // Commit decision, evaluated on the bit count held before this cycle's edge.
  always_comb begin
    do_commit = 1'b0;
    do_err    = 1'b0;
    if (rise_en) begin
      if (state == ST_FULL) begin
        do_commit = 1'b1;
      end else begin
        do_err = 1'b1;
      end
    end
  end

  // Register bank and commit reporting, all updated on the same edge.
  always_ff @(posedge clock_80 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        bank[i] <= REG_DEFAULTS[i];
      end
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_count <= '0;
    end else begin
      wr_strobe <= do_commit;
      frame_err <= do_err;
      if (do_commit) begin
        bank[sr[FRAME_BITS-1 -: ADDR_W]] <= sr[DATA_W-1:0];
        wr_addr     <= sr[FRAME_BITS-1 -: ADDR_W];
        wr_data     <= sr[DATA_W-1:0];
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign rd_data = bank[rd_addr];
  assign seq_reg = bank[ADDR_SEQUENCER][10:0];

endmodule
